// File: rtl/logic_pkg.sv
// Shared opcode encodings for the bitwise logic pipeline.
package logic_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_AND = 2'd0;
  localparam opcode_t OP_OR  = 2'd1;
  localparam opcode_t OP_NOR = 2'd2;
  localparam opcode_t OP_INV = 2'd3;

endpackage

// File: rtl/logic_gates32.sv
// Plain vector gate cells used by the result selector.
module and32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

module or32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

module nor32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = ~(a_i | b_i);
endmodule

module inv32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);
  assign y_o = ~a_i;
endmodule

// File: rtl/logic_sel32.sv
// Combinational result stage: all four gate outputs computed in parallel, opcode picks one.
module logic_sel32
  import logic_pkg::*;
#(
  parameter int W = 32
) (
  input  opcode_t      op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         zero_o
);

  logic [W-1:0] and_y;
  logic [W-1:0] or_y;
  logic [W-1:0] nor_y;
  logic [W-1:0] inv_y;

  and32 #(.W(W)) u_and (.a_i(a_i), .b_i(b_i), .y_o(and_y));
  or32  #(.W(W)) u_or  (.a_i(a_i), .b_i(b_i), .y_o(or_y));
  nor32 #(.W(W)) u_nor (.a_i(a_i), .b_i(b_i), .y_o(nor_y));
  inv32 #(.W(W)) u_inv (.a_i(a_i), .y_o(inv_y));

  always_comb begin
    y_o = and_y;
    case (op_i)
      OP_AND:  y_o = and_y;
      OP_OR:   y_o = or_y;
      OP_NOR:  y_o = nor_y;
      OP_INV:  y_o = inv_y;
      default: y_o = and_y;
    endcase
  end

  assign zero_o = ~|y_o;

endmodule

// File: rtl/logic_pipe32.sv
// Two-stage valid/ready pipeline around logic_sel32 with a completed-result counter.
module logic_pipe32
  import logic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [1:0]        OPCODE,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] Y,
  output logic              ZERO,
  output logic [CNT_W-1:0]  OP_COUNT
);

  logic              s1_v_q, s1_v_d;
  opcode_t           s1_op_q, s1_op_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic              s2_v_q, s2_v_d;
  logic [DATA_W-1:0] s2_y_q, s2_y_d;
  logic              s2_zero_q, s2_zero_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_xfer;
  logic              in_xfer;
  logic              s2_load;
  logic              s1_load;
  logic [DATA_W-1:0] res_y;
  logic              res_zero;

  logic_sel32 #(.W(DATA_W)) u_sel (
    .op_i   (s1_op_q),
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .y_o    (res_y),
    .zero_o (res_zero)
  );

  assign IN_READY  = ~RST & (~s1_v_q | ~s2_v_q | OUT_READY);
  assign out_xfer  = s2_v_q & OUT_READY;
  assign in_xfer   = IN_VALID & IN_READY;
  assign s2_load   = s1_v_q & (~s2_v_q | out_xfer);
  assign s1_load   = ~s1_v_q | s2_load;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_op_d   = s1_op_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s2_v_d    = s2_v_q;
    s2_y_d    = s2_y_q;
    s2_zero_d = s2_zero_q;
    cnt_d     = cnt_q;

    if (s1_load) s1_v_d = in_xfer;
    if (in_xfer) begin
      s1_op_d = OPCODE;
      s1_a_d  = A;
      s1_b_d  = B;
    end

    // Output regs are zeroed on drain so Y/ZERO read 0 whenever nothing is valid.
    if (s2_load) begin
      s2_v_d    = 1'b1;
      s2_y_d    = res_y;
      s2_zero_d = res_zero;
    end else if (out_xfer) begin
      s2_v_d    = 1'b0;
      s2_y_d    = '0;
      s2_zero_d = 1'b0;
    end

    if (out_xfer) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v_q    <= 1'b0;
      s1_op_q   <= OP_AND;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_y_q    <= '0;
      s2_zero_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_op_q   <= s1_op_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s2_v_q    <= s2_v_d;
      s2_y_q    <= s2_y_d;
      s2_zero_q <= s2_zero_d;
      cnt_q     <= cnt_d;
    end
  end

  assign OUT_VALID = s2_v_q;
  assign Y         = s2_y_q;
  assign ZERO      = s2_zero_q;
  assign OP_COUNT  = cnt_q;

endmodule

// File: tb/tb_logic_pipe32.sv
// Bench for logic_pipe32: transaction-queue reference model plus directed vectors and random traffic.
module tb_logic_pipe32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [1:0]  opcode;
  logic [31:0] a, b;
  logic        in_ready, out_valid, zero;
  logic [31:0] y;
  logic [15:0] op_count;
  logic        in_ready4, out_valid4, zero4;
  logic [31:0] y4;
  logic [3:0]  op_count4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] y;
    bit          vis;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mcnt;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        zero;
  } vec_t;

  logic_pipe32 dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OPCODE(opcode), .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .Y(y), .ZERO(zero), .OP_COUNT(op_count)
  );

  logic_pipe32 #(.DATA_W(32), .CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready4),
    .OPCODE(opcode), .A(a), .B(b), .OUT_VALID(out_valid4), .OUT_READY(out_ready),
    .Y(y4), .ZERO(zero4), .OP_COUNT(op_count4)
  );

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] z);
    case (op)
      2'd0:    return x & z;
      2'd1:    return x | z;
      2'd2:    return ~(x | z);
      default: return ~x;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: drive, check against the model at negedge, advance the model at posedge.
  task automatic cycle(input logic r, input logic iv, input logic [1:0] op,
                       input logic [31:0] da, input logic [31:0] db,
                       input logic ordy, output bit acc);
    logic        exp_ir, exp_ov, exp_z;
    logic [31:0] exp_y;
    bit          ox;
    rst = r; in_valid = iv; opcode = op; a = da; b = db; out_ready = ordy;
    @(negedge clk);
    exp_ir = !r && (mq.size() < 2 || ordy);
    exp_ov = (mq.size() > 0) && mq[0].vis;
    exp_y  = exp_ov ? mq[0].y : 32'h0;
    exp_z  = exp_ov && (exp_y == 32'h0);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    chk("y", y, exp_y);
    chk("zero", zero, exp_z);
    chk("op_count", op_count, mcnt[15:0]);
    chk("in_ready_cnt4", in_ready4, exp_ir);
    chk("out_valid_cnt4", out_valid4, exp_ov);
    chk("y_cnt4", y4, exp_y);
    chk("zero_cnt4", zero4, exp_z);
    chk("op_count_cnt4", op_count4, mcnt[3:0]);
    acc = iv && exp_ir;
    ox  = exp_ov && ordy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (ox) begin
        void'(mq.pop_front());
        mcnt++;
      end
      foreach (mq[i]) mq[i].vis = 1'b1;
      if (acc) mq.push_back('{ref_op(op, da, db), 1'b0});
    end
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] da, input logic [31:0] db, input logic ordy);
    bit acc;
    int k;
    acc = 0;
    k = 0;
    while (!acc && k < 50) begin
      cycle(1'b0, 1'b1, op, da, db, ordy, acc);
      k++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: op not accepted after %0d cycles", k);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, ordy, acc);
  endtask

  task automatic do_reset();
    bit acc;
    cycle(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, acc);
  endtask

  vec_t vecs[8];
  bit   acc;
  logic [31:0] y_hold;

  initial begin
    vecs[0] = '{2'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0};
    vecs[1] = '{2'd2, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};
    vecs[2] = '{2'd3, 32'h12345678, 32'h00000000, 32'hEDCBA987, 1'b0};
    vecs[3] = '{2'd1, 32'hA5A50000, 32'h00005A5A, 32'hA5A55A5A, 1'b0};
    vecs[4] = '{2'd0, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1};
    vecs[5] = '{2'd2, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[6] = '{2'd3, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h00000000, 1'b1};
    vecs[7] = '{2'd1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = 2'd0; a = 32'h0; b = 32'h0;
    mcnt = 0;
    @(posedge clk);
    #1;

    // Reset state, then ready on the first cycle out of reset.
    do_reset();
    do_reset();
    idle(1, 1'b0);

    // Directed vectors, one at a time through an empty pipe.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, acc);
      chk("vec_accept", acc, 1'b1);
      cycle(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, acc);
      chk("vec_out_valid", out_valid, 1'b1);
      chk("vec_y", y, vecs[i].y);
      chk("vec_zero", zero, vecs[i].zero);
      idle(1, 1'b1);
      if (i == 0) chk("vec0_count", op_count, 16'd1);
    end
    chk("vec_total_count", op_count, 16'd8);

    // Back-to-back stream of 8 with OUT_READY held high.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 2'(i), 32'h01010101 * i, 32'hF0F0F0F0 ^ i, 1'b1, acc);
      chk("b2b_accept", acc, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, acc);
      chk("b2b_tail_valid", out_valid, (i == 0));
    end
    chk("b2b_count", op_count, 16'd8);

    // Stall: three offered with OUT_READY low, only two fit.
    do_reset();
    cycle(1'b0, 1'b1, 2'd1, 32'h11110000, 32'h00002222, 1'b0, acc);
    chk("stall_acc1", acc, 1'b1);
    cycle(1'b0, 1'b1, 2'd0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, acc);
    chk("stall_acc2", acc, 1'b1);
    y_hold = y;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 2'd3, 32'h0000FFFF, 32'h0, 1'b0, acc);
      chk("stall_acc3_blocked", acc, 1'b0);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_y_stable", y, y_hold);
    end
    send(2'd3, 32'h0000FFFF, 32'h0, 1'b1);
    idle(4, 1'b1);
    chk("stall_count", op_count, 16'd3);

    // Narrow counter wrap: 17 completions.
    do_reset();
    for (int i = 0; i < 17; i++) send(2'd1, 32'(i), 32'h100, 1'b1);
    idle(3, 1'b1);
    chk("wrap_count4", op_count4, 4'd1);
    chk("wrap_count16", op_count, 16'd17);

    // Reset with both stages full discards in-flight work.
    do_reset();
    send(2'd0, 32'hFFFFFFFF, 32'h1234, 1'b1);
    send(2'd0, 32'hFFFFFFFF, 32'h5678, 1'b1);
    idle(3, 1'b1);
    send(2'd3, 32'hCAFEF00D, 32'h0, 1'b0);
    send(2'd3, 32'h0BADBEEF, 32'h0, 1'b0);
    idle(1, 1'b0);
    chk("full_before_reset", in_ready, 1'b0);
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", op_count, 16'd0);
    idle(4, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ~ra : $urandom;
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ra, rb, 1'($urandom_range(0, 2) != 0), acc);
    end
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
